// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares the single-port DM array between the
// pipeline memory stage (CPU port) and a DMA/debug engine (DMA port).
// Each access is a fixed-latency handshake: one mem_en strobe, LAT cycles
// of latency, then a one-cycle ack with registered read data.
// The CPU normally wins arbitration. A saturating starvation counter
// hands the next grant to DMA after STARVE_MAX CPU grants made while
// dma_req was waiting.
module dm_port_arbiter #(
    parameter int LAT        = 1,   // 1..4, mem_en cycle counts as cycle 1
    parameter int STARVE_MAX = 4    // CPU grants tolerated while DMA waits
) (
    input  logic        clk,
    input  logic        reset,
    // CPU port (pipeline stage M)
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    // DMA / debug port
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_be,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    // Memory side
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int          CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [2:0]  LAT_INIT   = 3'(LAT);

    logic [1:0]    r_state;
    logic          r_owner;
    logic [CW-1:0] r_starve_cnt;
    logic [2:0]    r_lat_cnt;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_be;
    logic          r_cpu_ack;
    logic          r_dma_ack;
    logic [31:0]   r_cpu_rdata;
    logic [31:0]   r_dma_rdata;

    logic          w_grant_dma;
    logic          w_grant_cpu;
    logic          w_sel_we;
    logic [31:0]   w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic [3:0]    w_sel_be;
    logic          w_unused;

    // Byte-lane selection belongs to the aligner upstream; the low address
    // bits are intentionally dropped here.
    assign w_unused = &{1'b0, cpu_addr[1:0], dma_addr[1:0]};

    // Arbitration and selection of the winning port's request fields.
    always_comb begin
        w_grant_dma = dma_req && (!cpu_req || (r_starve_cnt == STARVE_LIM));
        w_grant_cpu = cpu_req && !w_grant_dma;
        w_sel_we    = w_grant_dma ? dma_we    : cpu_we;
        w_sel_addr  = w_grant_dma ? dma_addr  : cpu_addr;
        w_sel_wdata = w_grant_dma ? dma_wdata : cpu_wdata;
        w_sel_be    = w_grant_dma ? dma_be    : cpu_be;
    end

    // Access sequencer: IDLE arbitrates, BUSY waits out the latency, RESP acks.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; blocking writes would create ordering races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_CPU;
            r_starve_cnt <= '0;
            r_lat_cnt    <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_cpu_ack    <= 1'b0;
            r_dma_ack    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_dma || w_grant_cpu) begin
                        r_owner     <= w_grant_dma ? OWN_DMA : OWN_CPU;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= {w_sel_addr[31:2], 2'b00};
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_be    <= w_sel_we ? w_sel_be : 4'b0000;
                        r_lat_cnt   <= LAT_INIT;
                        r_state     <= S_BUSY;
                    end
                    // Starvation counter only advances on CPU wins over a waiting DMA.
                    if (w_grant_dma || !dma_req) begin
                        r_starve_cnt <= '0;
                    end else if (w_grant_cpu && (r_starve_cnt != STARVE_LIM)) begin
                        r_starve_cnt <= r_starve_cnt + CW'(1);
                    end
                end
                S_BUSY: begin
                    r_mem_en  <= 1'b0;
                    r_lat_cnt <= r_lat_cnt - 3'd1;
                    if (r_lat_cnt == 3'd1) begin
                        if (r_owner == OWN_DMA) begin
                            r_dma_ack <= 1'b1;
                            if (!r_mem_we) r_dma_rdata <= mem_rdata;
                        end else begin
                            r_cpu_ack <= 1'b1;
                            if (!r_mem_we) r_cpu_rdata <= mem_rdata;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_cpu_ack <= 1'b0;
                    r_dma_ack <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign cpu_ack   = r_cpu_ack;
    assign dma_ack   = r_dma_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign cpu_stall = cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter. Two instances share all request
// inputs: u_dut1 runs with LAT=1, u_dut3 with LAT=3. Each scenario checks
// only the instance it targets.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_be = '0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic [3:0]  dma_be = '0;

    logic [31:0] cpu_rdata1, dma_rdata1, mem_addr1, mem_wdata1;
    logic        cpu_ack1, cpu_stall1, dma_ack1, mem_en1, mem_we1;
    logic [3:0]  mem_be1;
    logic [31:0] mem_rdata1 = '0;

    logic [31:0] cpu_rdata3, dma_rdata3, mem_addr3, mem_wdata3;
    logic        cpu_ack3, cpu_stall3, dma_ack3, mem_en3, mem_we3;
    logic [3:0]  mem_be3;
    logic [31:0] mem_rdata3 = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1), .cpu_stall(cpu_stall1),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_be(dma_be),
        .dma_rdata(dma_rdata1), .dma_ack(dma_ack1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_be(mem_be1), .mem_rdata(mem_rdata1)
    );

    dm_port_arbiter #(.LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3), .cpu_stall(cpu_stall3),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_be(dma_be),
        .dma_rdata(dma_rdata3), .dma_ack(dma_ack3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_be(mem_be3), .mem_rdata(mem_rdata3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset   = 1'b1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Global time guard so a stuck DUT cannot hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n_grant;
        int last;
        int waited;
        bit seen;

        // ---------------- Reset state ----------------
        #1;
        check("rst_state",     32'(u_dut1.r_state), 32'd0);
        check("rst_mem_en",    32'(mem_en1), 32'd0);
        check("rst_mem_addr",  mem_addr1, 32'h0);
        check("rst_acks",      32'({cpu_ack1, dma_ack1}), 32'd0);
        check("rst_rdata",     cpu_rdata1 | dma_rdata1, 32'h0);
        check("rst_starve",    32'(u_dut1.r_starve_cnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ---------------- 1: CPU read, LAT=1 ----------------
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0104;
        mem_rdata1 = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t1_stall_pre",  32'(cpu_stall1), 32'd1);
        check("t1_en_pre",     32'(mem_en1), 32'd0);
        @(negedge clk);
        check("t1_mem_en",     32'(mem_en1), 32'd1);
        check("t1_mem_addr",   mem_addr1, 32'h0000_0104);
        check("t1_mem_be",     32'(mem_be1), 32'd0);
        check("t1_mem_we",     32'(mem_we1), 32'd0);
        check("t1_ack_early",  32'(cpu_ack1), 32'd0);
        check("t1_stall_busy", 32'(cpu_stall1), 32'd1);
        @(negedge clk);
        check("t1_ack",        32'(cpu_ack1), 32'd1);
        check("t1_rdata",      cpu_rdata1, 32'hDEAD_BEEF);
        check("t1_en_off",     32'(mem_en1), 32'd0);
        check("t1_stall_ack",  32'(cpu_stall1), 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        check("t1_ack_pulse",  32'(cpu_ack1), 32'd0);

        // ---------------- 2: CPU write, unaligned address ----------------
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0203;
        cpu_be = 4'b1000; cpu_wdata = 32'h7F00_0000;
        mem_rdata1 = 32'hAAAA_5555;
        @(negedge clk);
        @(negedge clk);
        check("t2_mem_en",     32'(mem_en1), 32'd1);
        check("t2_mem_addr",   mem_addr1, 32'h0000_0200);
        check("t2_mem_we",     32'(mem_we1), 32'd1);
        check("t2_mem_be",     32'(mem_be1), 32'h8);
        check("t2_mem_wdata",  mem_wdata1, 32'h7F00_0000);
        @(negedge clk);
        check("t2_ack",        32'(cpu_ack1), 32'd1);
        check("t2_rdata_kept", cpu_rdata1, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'b0000;

        // ---------------- 3: starvation, STARVE_MAX=4 ----------------
        do_reset();
        cpu_addr = 32'h0000_0100; cpu_we = 1'b0;
        dma_addr = 32'h0000_0300; dma_we = 1'b0;
        mem_rdata1 = 32'hCAFE_0001;
        cpu_req = 1'b1; dma_req = 1'b1;
        n_grant = 0;
        for (int cyc = 0; cyc < 40 && n_grant < 5; cyc++) begin
            @(negedge clk);
            if (mem_en1) begin
                check($sformatf("t3_grant%0d_addr", n_grant), mem_addr1,
                      (n_grant < 4) ? 32'h0000_0100 : 32'h0000_0300);
                check($sformatf("t3_grant%0d_starve", n_grant), 32'(u_dut1.r_starve_cnt),
                      (n_grant < 4) ? 32'(n_grant + 1) : 32'd0);
                n_grant++;
            end
        end
        check("t3_grant_count", 32'(n_grant), 32'd5);
        seen = 1'b0;
        for (int cyc = 0; cyc < 6 && !seen; cyc++) begin
            @(negedge clk);
            if (dma_ack1) seen = 1'b1;
        end
        check("t3_dma_ack_seen", 32'(seen), 32'd1);
        check("t3_dma_rdata",    dma_rdata1, 32'hCAFE_0001);
        dma_req = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t3_starve_clear", 32'(u_dut1.r_starve_cnt), 32'd0);

        // ---------------- 4: DMA read, LAT=3 ----------------
        do_reset();
        mem_rdata3 = 32'hBAD0_BAD0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0040;
        @(posedge clk); #1;
        check("t4_mem_en",     32'(mem_en3), 32'd1);
        check("t4_mem_addr",   mem_addr3, 32'h0000_0040);
        check("t4_stall_c1",   32'(cpu_stall3), 32'd0);
        @(posedge clk); #1;
        check("t4_en_off",     32'(mem_en3), 32'd0);
        check("t4_ack_c2",     32'(dma_ack3), 32'd0);
        @(posedge clk); #1;
        check("t4_ack_c3",     32'(dma_ack3), 32'd0);
        check("t4_stall_c3",   32'(cpu_stall3), 32'd0);
        mem_rdata3 = 32'h1234_5678;
        @(posedge clk); #1;
        check("t4_ack",        32'(dma_ack3), 32'd1);
        check("t4_rdata",      dma_rdata3, 32'h1234_5678);
        check("t4_stall_c4",   32'(cpu_stall3), 32'd0);
        mem_rdata3 = 32'hBAD0_BAD0;
        dma_req = 1'b0;
        @(posedge clk); #1;
        check("t4_ack_pulse",  32'(dma_ack3), 32'd0);
        @(posedge clk); #1;

        // ---------------- 5: reset during BUSY, LAT=3 ----------------
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0080;
        mem_rdata3 = 32'h55AA_55AA;
        @(posedge clk); #1;
        check("t5_busy",       32'(u_dut3.r_state), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("t5_rst_state",  32'(u_dut3.r_state), 32'd0);
        check("t5_rst_mem_en", 32'(mem_en3), 32'd0);
        check("t5_rst_acks",   32'({cpu_ack3, dma_ack3}), 32'd0);
        check("t5_rst_dmard",  dma_rdata3, 32'h0);
        check("t5_rst_cpurd",  cpu_rdata3, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_en_early",   32'(mem_en3), 32'd0);
        @(negedge clk);
        check("t5_regrant_en", 32'(mem_en3), 32'd1);
        check("t5_regrant_ad", mem_addr3, 32'h0000_0080);
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 10) begin
            @(negedge clk);
            waited++;
            if (cpu_ack3) seen = 1'b1;
        end
        check("t5_ack_latency", 32'(waited), 32'd3);
        check("t5_rdata",       cpu_rdata3, 32'h55AA_55AA);
        cpu_req = 1'b0;

        // ---------------- 6: 10 CPU accesses, DMA idle ----------------
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
        n_grant = 0;
        last    = 0;
        for (int cyc = 0; cyc < 60 && n_grant < 10; cyc++) begin
            @(negedge clk);
            if (mem_en1) begin
                if (n_grant > 0)
                    check($sformatf("t6_period%0d", n_grant), 32'(cyc - last), 32'd3);
                check($sformatf("t6_starve%0d", n_grant), 32'(u_dut1.r_starve_cnt), 32'd0);
                last = cyc;
                n_grant++;
                if (n_grant == 10) cpu_req = 1'b0;
            end
        end
        check("t6_grant_count", 32'(n_grant), 32'd10);
        @(negedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
